// File: rtl/apb_pkg.sv
// Shared definitions for the 8-bit peripheral bus: state encoding used by
// both the requester and apb_slave, plus default bus widths.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the ACCESS phase. Clear has priority over enable;
// the count saturates at TIMEOUT and tc flags that terminal value.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == TC_VAL);

  // Next count: clear, count up while enabled, hold at terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester. One command at a time is accepted on the
// cmd port (valid/ready: a transfer happens at a posedge where both are high;
// the requester holds valid and payload stable until then), sequenced through
// SETUP and ACCESS, and answered with a one-cycle rsp_valid pulse. ACCESS is
// bounded by a wait-state timeout; pready wins if it arrives on the last
// allowed cycle. Every output comes straight from a flop.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel0,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              psel0_q, psel0_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  apb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (preset),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  // The APB address/data/direction flops double as the command latch: they
  // are loaded at the handshake and held until the transfer ends.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    psel0_d     = psel0_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel0_d     = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_clr   = 1'b1;
      end

      ACCESS: begin
        if (pready || cnt_tc) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          psel0_d     = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          rsp_valid_d = 1'b1;
          if (pready) begin
            rsp_err_d = pslverr;
            if (!pwrite_q && !pslverr) begin
              rsp_rdata_d = prdata;
            end
          end else begin
            rsp_err_d = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        psel0_d     = 1'b0;
        penable_d   = 1'b0;
        pwrite_d    = 1'b0;
        paddr_d     = '0;
        pwdata_d    = '0;
      end
    endcase
  end

  // FSM state and all registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (preset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel0_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel0_q     <= psel0_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel0     = psel0_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios followed by random transfers.
// The bench plays the APB slave with a memory model; each accepted command
// pushes its expected {err, rdata} on exp_q, popped when rsp_valid arrives.
// Cycle numbering: handshake cycle is cycle 0, response appears in cycle
// waits+3, or TIMEOUT+3 when the slave never answers.
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          preset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel0;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic          pslverr;
  logic [DW-1:0] prdata;

  int total = 0;
  int bad   = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] mem[256];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  apb_master #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .preset   (preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel0    (psel0),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .prdata   (prdata)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"},   rsp_err,   0);
    chk({tag, "_psel0"},     psel0,     0);
    chk({tag, "_penable"},   penable,   0);
    chk({tag, "_pwrite"},    pwrite,    0);
    chk({tag, "_paddr"},     paddr,     0);
    chk({tag, "_pwdata"},    pwdata,    0);
    chk({tag, "_state"},     dut.state_q, IDLE);
  endtask

  // ---------------- driver: one full transfer ----------------
  // Called in the cycle where the command is presented (cycle 0). Returns in
  // the response cycle so the next call can hand-shake back-to-back. With
  // hold set, cmd_valid stays high carrying the next command while busy.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int waits, input logic serr,
                      input logic hold, input logic nwr,
                      input logic [AW-1:0] na, input logic [DW-1:0] nwd);
    logic          timed_out;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    logic [DW:0]   exp;
    int            exp_lat;
    int            cyc;
    int            k;
    logic          done;

    // reference model of the outcome
    timed_out = (waits > TMO);
    exp_lat   = timed_out ? TMO + 3 : waits + 3;
    exp_err   = timed_out ? 1'b1 : serr;
    exp_rd    = (wr || exp_err) ? '0 : mem[a];

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    chk("hs_ready", cmd_ready, 1);
    exp_q.push_back({exp_err, exp_rd});

    step();
    cyc = 1;
    if (hold) begin
      cmd_write = nwr;
      cmd_addr  = na;
      cmd_wdata = nwd;
    end else begin
      cmd_valid = 1'b0;
    end
    chk("setup_psel",   psel0,     1);
    chk("setup_pen",    penable,   0);
    chk("setup_addr",   paddr,     a);
    chk("setup_wr",     pwrite,    wr);
    chk("setup_wdata",  pwdata,    wd);
    chk("setup_ready",  cmd_ready, 0);
    chk("setup_rspv",   rsp_valid, 0);

    step();
    cyc  = 2;
    done = 1'b0;
    while (!done && cyc < 64) begin
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        k = cyc - 2;
        chk("acc_psel",  psel0,     1);
        chk("acc_pen",   penable,   1);
        chk("acc_addr",  paddr,     a);
        chk("acc_wr",    pwrite,    wr);
        chk("acc_wdata", pwdata,    wd);
        chk("acc_ready", cmd_ready, 0);
        if (k == waits) begin
          pready  = 1'b1;
          pslverr = serr;
          prdata  = wr ? 8'($urandom) : mem[a];
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom_range(0, 1));
          prdata  = 8'($urandom);
        end
        step();
        cyc++;
      end
    end
    pready  = 1'b0;
    pslverr = 1'b0;

    chk("rsp_seen", done, 1);
    chk("rsp_latency", cyc, exp_lat);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk("rsp_err",   rsp_err,   exp[DW]);
      chk("rsp_rdata", rsp_rdata, exp[DW-1:0]);
    end
    chk("rsp_ready", cmd_ready, 1);
    chk("rsp_psel",  psel0,     0);
    chk("rsp_pen",   penable,   0);
    chk("rsp_paddr", paddr,     0);

    if (wr && !exp_err) mem[a] = wd;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_rspv", rsp_valid, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    step();
    step();
    step();
    chk_reset_vals("reset");
    preset = 1'b0;
    step();

    // write 0xA5 to 0x10, zero wait states
    xfer(1'b1, 8'h10, 8'hA5, 0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    // read it back with two wait states
    xfer(1'b0, 8'h10, 8'h00, 2, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    // read with slave error: data must be zeroed
    xfer(1'b0, 8'h10, 8'h00, 1, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(2);

    // slave never answers: timeout abort
    xfer(1'b0, 8'h22, 8'h00, 1000, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("tmo_state", dut.state_q, IDLE);
    idle(1);

    // back-to-back with cmd_valid held during the busy period
    xfer(1'b1, 8'h05, 8'h3C, 0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
    xfer(1'b0, 8'h05, 8'h00, 0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    // reset during ACCESS with pready arriving in the same cycle
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h33;
    cmd_wdata = 8'h00;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rstmid_pen", penable, 1);
    preset = 1'b1;
    pready = 1'b1;
    prdata = 8'h5A;
    step();
    preset = 1'b0;
    pready = 1'b0;
    chk_reset_vals("rstmid");
    idle(2);
    xfer(1'b1, 8'h33, 8'h77, 1, 1'b0, 1'b0, 1'b0, '0, '0);
    xfer(1'b0, 8'h33, 8'h00, 0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    // random traffic on a small address window so reads hit earlier writes
    for (int t = 0; t < 40; t++) begin
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      int            w;
      logic          se;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      wd = 8'($urandom);
      w  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5));
      se = ($urandom_range(0, 4) == 0);
      xfer(wr, a, wd, w, se, 1'b0, 1'b0, '0, '0);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    chk("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester for the 8-bit peripheral bus, sitting directly upstream of `apb_slave`. It accepts one command at a time on a valid/ready request port and sequences the APB IDLE → SETUP → ACCESS protocol. It waits for `pready` with a bounded timeout, then returns read data and error status on a one-cycle response strobe.

## Interface
- `ADDR_W`, 8, APB address width
- `DATA_W`, 8, APB data width
- `TIMEOUT`, 16, max ACCESS cycles with `pready` low before abort (≥1)

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `preset`  in  1  reset; synchronous, active-high
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at posedge
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  target address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and on error
- `rsp_err`  out  1  `pslverr` sampled at completion, or timeout
- `psel0`  out  1  APB select
- `penable`  out  1  APB enable
- `pwrite`  out  1  APB direction
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `pready`  in  1  slave ready
- `pslverr`  in  1  slave error
- `prdata`  in  DATA_W  slave read data

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - `cmd_ready`=1.
  - On handshake: latch `cmd_write`/`cmd_addr`/`cmd_wdata` and go to SETUP.
- SETUP:
  - `psel0`=1, `penable`=0, `paddr`/`pwrite`/`pwdata` = latched command.
  - Always goes to ACCESS next cycle.
- ACCESS:
  - `psel0`=1, `penable`=1, address, data and direction held stable.
  - Completes at the first posedge with `pready`=1, then returns to IDLE.
- Wait counter:
  - Clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - At count == TIMEOUT the transfer aborts: IDLE, `rsp_err`=1, `rsp_rdata`=0.
- Completion:
  - Read: capture `prdata` into `rsp_rdata`.
  - Write: `rsp_rdata`=0.
  - `rsp_err` = `pslverr` sampled at the completing edge.
- In IDLE, `psel0`/`penable`/`pwrite`/`paddr`/`pwdata` are driven 0.
- `cmd_valid` while busy is ignored (`cmd_ready`=0). The requester holds the command until accepted.
- Exactly one `rsp_valid` per accepted command, except when reset intervenes.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `psel0`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0. FSM=IDLE, counter=0.
- Minimum latency with `pready` already high at ACCESS:
  - Handshake at edge N.
  - SETUP during cycle N+1.
  - ACCESS during N+2, completing at edge N+3.
  - `rsp_valid` high during cycle N+3.
- Each `pready`=0 cycle in ACCESS adds one cycle.
- Back-to-back: `cmd_ready`=1 in the same cycle as `rsp_valid`. A new command is accepted there, giving 3 cycles/transfer peak.
- Timeout: with `pready` stuck 0, `rsp_valid`+`rsp_err` occur TIMEOUT+3 cycles after the handshake edge.
- `pslverr` is honoured only on the completing cycle and ignored while `pready`=0.
- Reset mid-transfer: at the next posedge all outputs return to reset values and the pending transfer is dropped with no response. A `pready` arriving in the same cycle as `preset` is ignored.
- `psel0` is never deasserted between SETUP and completion. `penable` is never high outside ACCESS.

## Structure
- Shared package `apb_pkg`:
  - state encoding IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, also used by `apb_slave`
  - default `ADDR_W`/`DATA_W`
- Sub-module `apb_timeout_cnt`: clear/enable/terminal-count counter, width $clog2(TIMEOUT+1), flag at TIMEOUT.
- Top holds the FSM, command latch and response registers.

## Test plan
- Reset, then write 0xA5 to 0x10 with `pready`=1 → SETUP at cycle 1, ACCESS at cycle 2 (`paddr`=0x10, `pwdata`=0xA5, `pwrite`=1), `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0 at cycle 3.
- Read 0x10, slave returns 0xA5 after 2 wait states → `psel0`/`penable`/`paddr` stable throughout, `rsp_rdata`=0xA5 at cycle 5.
- Read with `pslverr`=1 on the completing cycle → `rsp_err`=1, `rsp_rdata`=0x00 (captured `prdata` ignored).
- `pready` held 0, TIMEOUT=16 → abort with `rsp_err`=1 exactly 19 cycles after the handshake, then FSM in IDLE and `cmd_ready`=1.
- Two commands back-to-back with `cmd_valid` held → second handshake in the `rsp_valid` cycle, APB transfers 3 cycles apart, `cmd_valid` during busy not accepted.
- Assert `preset` during ACCESS → next cycle all outputs at reset values, no `rsp_valid`, next command runs normally.
